// File: rtl/lc3_pkg.sv
// Shared types for the LC-3 sequencer: FSM state encoding, opcodes and
// datapath mux/ALU select values.
package lc3_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_18, S_33, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22,
    S_12, S_04, S_21, S_20, S_06,
    S_25, S_27, S_07, S_23, S_16,
    S_PAUSE_A, S_PAUSE_B
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PC_PLUS1 = 2'd0;
  localparam logic [1:0] PC_BUS   = 2'd1;
  localparam logic [1:0] PC_ADDER = 2'd2;

  localparam logic [1:0] DR_IR11 = 2'd0;
  localparam logic [1:0] DR_R7   = 2'd1;

  localparam logic [1:0] SR1_IR11 = 2'd0;
  localparam logic [1:0] SR1_IR8  = 2'd1;

  localparam logic A1_PC  = 1'b0;
  localparam logic A1_SR1 = 1'b1;

  localparam logic [1:0] A2_ZERO  = 2'd0;
  localparam logic [1:0] A2_OFF6  = 2'd1;
  localparam logic [1:0] A2_OFF9  = 2'd2;
  localparam logic [1:0] A2_OFF11 = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_AND   = 2'd1;
  localparam logic [1:0] ALU_NOT   = 2'd2;
  localparam logic [1:0] ALU_PASSA = 2'd3;

  function automatic logic is_mem_state(state_t s);
    return (s == S_33) || (s == S_25) || (s == S_16);
  endfunction

endpackage

// File: rtl/lc3_isdu_if.sv
// Control/status bundle between the ISDU (master) and the datapath/board (slave).
interface lc3_isdu_if;
  logic       Run, Continue, IR_5, IR_11, BEN, Mem_Ready;
  logic [3:0] Opcode;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic [1:0] PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK;
  logic       ADDR1MUX, SR2MUX, MIO_EN;
  logic       Mem_OE, Mem_WE;

  modport master (
    input  Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
    output GatePC, GateMDR, GateALU, GateMARMUX,
           LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK,
           ADDR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE
  );

  modport slave (
    output Run, Continue, Opcode, IR_5, IR_11, BEN, Mem_Ready,
    input  GatePC, GateMDR, GateALU, GateMARMUX,
           LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
           PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK,
           ADDR1MUX, SR2MUX, MIO_EN, Mem_OE, Mem_WE
  );
endinterface

// File: rtl/lc3_mem_wait.sv
// Fixed-length SRAM access timer: done rises on the third cycle that start is held.
module lc3_mem_wait (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic done
);

  logic [1:0] cnt;

  // Memory states are never back to back, so dropping start clears for the next entry.
  always_ff @(posedge Clk) begin
    if (Reset || !start)
      cnt <= 2'd0;
    else if (cnt != 2'd2)
      cnt <= cnt + 2'd1;
  end

  assign done = start && (cnt == 2'd2);

endmodule

// File: rtl/lc3_isdu.sv
// LC-3 instruction sequencer/decoder (Moore FSM).
// Define LC3_ISDU_MEM_READY_EN to pace memory states by Mem_Ready instead of a fixed 3-cycle wait.
module lc3_isdu
  import lc3_pkg::*;
(
  input logic        Clk,
  input logic        Reset,
  lc3_isdu_if.master bus
);

  state_t state, next_state;
  logic   mem_done;

`ifdef LC3_ISDU_MEM_READY_EN
  assign mem_done = bus.Mem_Ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = bus.Mem_Ready;

  lc3_mem_wait u_wait (
    .Clk   (Clk),
    .Reset (Reset),
    .start (is_mem_state(state)),
    .done  (mem_done)
  );
`endif

  always_ff @(posedge Clk) begin
    if (Reset)
      state <= S_HALTED;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_HALTED:  if (bus.Run) next_state = S_18;
      S_18:      next_state = S_33;
      S_33:      if (mem_done) next_state = S_35;
      S_35:      next_state = S_32;
      S_32: begin
        case (bus.Opcode)
          OP_ADD:   next_state = S_01;
          OP_AND:   next_state = S_05;
          OP_NOT:   next_state = S_09;
          OP_BR:    next_state = S_00;
          OP_JMP:   next_state = S_12;
          OP_JSR:   next_state = S_04;
          OP_LDR:   next_state = S_06;
          OP_STR:   next_state = S_07;
          OP_PAUSE: next_state = S_PAUSE_A;
          default:  next_state = S_18;
        endcase
      end
      S_00:      next_state = bus.BEN ? S_22 : S_18;
      S_04:      next_state = bus.IR_11 ? S_21 : S_20;
      S_06:      next_state = S_25;
      S_25:      if (mem_done) next_state = S_27;
      S_07:      next_state = S_23;
      S_23:      next_state = S_16;
      S_16:      if (mem_done) next_state = S_18;
      S_PAUSE_A: if (bus.Continue) next_state = S_PAUSE_B;
      S_PAUSE_B: if (!bus.Continue) next_state = S_18;
      default:   next_state = S_18;
    endcase
  end

  always_comb begin
    bus.GatePC = 1'b0;  bus.GateMDR = 1'b0;  bus.GateALU = 1'b0;  bus.GateMARMUX = 1'b0;
    bus.LD_MAR = 1'b0;  bus.LD_MDR = 1'b0;   bus.LD_IR = 1'b0;    bus.LD_BEN = 1'b0;
    bus.LD_CC = 1'b0;   bus.LD_REG = 1'b0;   bus.LD_PC = 1'b0;    bus.LD_LED = 1'b0;
    bus.PCMUX = PC_PLUS1;  bus.DRMUX = DR_IR11;  bus.SR1MUX = SR1_IR11;
    bus.ADDR2MUX = A2_ZERO; bus.ALUK = ALU_ADD;  bus.ADDR1MUX = A1_PC;
    bus.SR2MUX = 1'b0;  bus.MIO_EN = 1'b0;
    bus.Mem_OE = 1'b1;  bus.Mem_WE = 1'b1;
    case (state)
      S_18: begin
        bus.GatePC = 1'b1; bus.LD_MAR = 1'b1; bus.PCMUX = PC_PLUS1; bus.LD_PC = 1'b1;
      end
      S_33, S_25: begin
        bus.Mem_OE = 1'b0; bus.MIO_EN = 1'b1; bus.LD_MDR = mem_done;
      end
      S_35: begin
        bus.GateMDR = 1'b1; bus.LD_IR = 1'b1;
      end
      S_32: bus.LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        bus.SR1MUX = SR1_IR8; bus.SR2MUX = bus.IR_5; bus.GateALU = 1'b1;
        bus.LD_REG = 1'b1; bus.LD_CC = 1'b1; bus.DRMUX = DR_IR11;
        bus.ALUK = (state == S_01) ? ALU_ADD : (state == S_05) ? ALU_AND : ALU_NOT;
      end
      S_22: begin
        bus.ADDR1MUX = A1_PC; bus.ADDR2MUX = A2_OFF9; bus.PCMUX = PC_ADDER; bus.LD_PC = 1'b1;
      end
      S_12, S_20: begin
        bus.SR1MUX = SR1_IR8; bus.ALUK = ALU_PASSA; bus.GateALU = 1'b1;
        bus.PCMUX = PC_BUS; bus.LD_PC = 1'b1;
      end
      S_04: begin
        bus.GatePC = 1'b1; bus.DRMUX = DR_R7; bus.LD_REG = 1'b1;
      end
      S_21: begin
        bus.ADDR1MUX = A1_PC; bus.ADDR2MUX = A2_OFF11; bus.PCMUX = PC_ADDER; bus.LD_PC = 1'b1;
      end
      S_06, S_07: begin
        bus.SR1MUX = SR1_IR8; bus.ADDR1MUX = A1_SR1; bus.ADDR2MUX = A2_OFF6;
        bus.GateMARMUX = 1'b1; bus.LD_MAR = 1'b1;
      end
      S_27: begin
        bus.GateMDR = 1'b1; bus.DRMUX = DR_IR11; bus.LD_REG = 1'b1; bus.LD_CC = 1'b1;
      end
      // Store data comes from the register file through the ALU, not from memory.
      S_23: begin
        bus.SR1MUX = SR1_IR11; bus.ALUK = ALU_PASSA; bus.GateALU = 1'b1;
        bus.MIO_EN = 1'b0; bus.LD_MDR = 1'b1;
      end
      S_16:                 bus.Mem_WE = 1'b0;
      S_PAUSE_A, S_PAUSE_B: bus.LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/lc3_isdu.md
# lc3_isdu

Instruction sequencer/decoder (ISDU) for the LC-3 core: a Moore state machine that drives every gate, load and mux-select input of the datapath and the active-low SRAM strobes. It sits directly upstream of the datapath. It consumes the opcode, IR[5], IR[11] and BEN from the datapath, and the Run/Continue switches from the board top level.

## Interface
- No parameters.
- Clk  in  1  system clock; all state changes on its rising edge.
- Reset  in  1  synchronous, active-high; one clock, one reset.
- Run  in  1  start execution from Halted.
- Continue  in  1  pause-release handshake.
- Opcode  in  4  IR[15:12].
- IR_5  in  1  immediate select for ADD/AND.
- IR_11  in  1  JSR vs JSRR select.
- BEN  in  1  branch-enable flag from datapath.
- Mem_Ready  in  1  SRAM access complete; used only when LC3_ISDU_MEM_READY_EN is defined.
- GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers; at most one high per cycle.
- LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  register loads.
- PCMUX, DRMUX, SR1MUX, ADDR2MUX, ALUK  out  2 each  mux/ALU selects.
- ADDR1MUX, SR2MUX, MIO_EN  out  1 each.
- Mem_OE, Mem_WE  out  1 each  active-low SRAM strobes.

## Operation
- Select encodings:
  - PCMUX: 0=PC+1, 1=BUS, 2=adder.
  - DRMUX: 0=IR[11:9], 1=R7.
  - SR1MUX: 0=IR[11:9], 1=IR[8:6].
  - ADDR1MUX: 0=PC, 1=SR1.
  - ADDR2MUX: 0=zero, 1=off6, 2=off9, 3=off11.
  - ALUK: 0=ADD, 1=AND, 2=NOT, 3=PASSA.
  - MIO_EN=1 routes memory data into MDR.
- Outputs are a pure decode of the current state. In every state, any output not listed takes its default: 0, except Mem_OE=Mem_WE=1.
- Fetch:
  - S18: GatePC, LD_MAR, PCMUX=0, LD_PC.
  - S33: Mem_OE=0, MIO_EN, LD_MDR on the final wait cycle.
  - S35: GateMDR, LD_IR.
  - S32: LD_BEN, then dispatch on Opcode.
- ADD (0001) S01 / AND (0101) S05: SR1MUX=1, SR2MUX=IR_5, ALUK=0/1, GateALU, LD_REG, LD_CC, DRMUX=0. Then go to S18.
- NOT (1001) S09: same as ADD/AND with ALUK=2.
- BR (0000):
  - S00: if BEN go to S22, else go to S18.
  - S22: ADDR1MUX=0, ADDR2MUX=2, PCMUX=2, LD_PC.
- JMP (1100) S12: SR1MUX=1, ALUK=3, GateALU, PCMUX=1, LD_PC.
- JSR (0100):
  - S04: GatePC, DRMUX=1, LD_REG.
  - If IR_11, go to S21: ADDR1MUX=0, ADDR2MUX=3, PCMUX=2, LD_PC.
  - Otherwise go to S20: SR1MUX=1, ALUK=3, GateALU, PCMUX=1, LD_PC.
- LDR (0110):
  - S06: SR1MUX=1, ADDR1MUX=1, ADDR2MUX=1, GateMARMUX, LD_MAR.
  - S25: read, same as S33.
  - S27: GateMDR, DRMUX=0, LD_REG, LD_CC.
- STR (0111):
  - S07: MAR computed as in S06.
  - S23: SR1MUX=0, ALUK=3, GateALU, MIO_EN=0, LD_MDR.
  - S16: Mem_WE=0 for the whole access.
- PAUSE (1101):
  - PAUSE_A: LD_LED; hold until Continue=1.
  - PAUSE_B: LD_LED; hold until Continue=0, then go to S18.
- Any other opcode: S32 goes straight to S18 (NOP).
- HALTED: all outputs at their defaults; go to S18 when Run=1.

## Timing
- Reset (synchronous) puts the FSM in HALTED. Outputs reach their default values in the cycle after the Reset edge. This is true from any state, including mid-write, where Mem_WE deasserts the next cycle.
- Memory states (S33, S25, S16) last exactly 3 cycles in the default build. A 2-bit wait counter clears on state entry. LD_MDR pulses only on the third cycle.
- Instruction latency in the default build, counted from S18 entry to the return to S18:
  - ADD/AND/NOT: 7 cycles.
  - BR not taken: 7. BR taken: 8.
  - JMP: 7. JSR: 8.
  - LDR: 11. STR: 11.
- Run is sampled only in HALTED. Continue is sampled only in the PAUSE states.
- A Continue pulse shorter than one cycle may be missed; the board debounces it upstream.

## Configuration
- LC3_ISDU_MEM_READY_EN defined:
  - Memory states hold until Mem_Ready=1 is sampled; the strobe stays asserted meanwhile.
  - LD_MDR (read) asserts in the cycle Mem_Ready is high.
  - The FSM exits on the next edge. There is no timeout.
- Not defined: fixed 3-cycle access; Mem_Ready is ignored.

## Structure
- Package lc3_pkg holds:
  - the state enum;
  - the opcode localparams (OP_ADD, OP_AND, OP_NOT, OP_BR, OP_JMP, OP_JSR, OP_LDR, OP_STR, OP_PAUSE);
  - the ALUK and mux-select constants.
- Sub-module lc3_mem_wait: a 2-bit wait counter with a start input and a done output. It is selected against Mem_Ready by the macro.
- State register and next-state/output decode live in lc3_isdu.

## Test plan
- Reset asserted in S33 → next cycle HALTED, Mem_OE=1, all LD_*=0. With Run=0, the FSM stays HALTED for 10 cycles.
- Run=1, Opcode=0001, IR_5=1 → state sequence 18,33,33,33,35,32,01,18. In S01: GateALU=1, LD_REG=1, LD_CC=1, SR2MUX=1, ALUK=0.
- Opcode=0000: with BEN=0, S00 goes to S18. With BEN=1, S22 is entered with PCMUX=2, ADDR2MUX=2, LD_PC=1.
- Opcode=0110 with the macro defined and Mem_Ready held low 5 cycles → S25 lasts 6 cycles, Mem_OE=0 throughout, and LD_MDR is high only in the last of them.
- Opcode=0111 → Mem_WE=0 for exactly 3 cycles in S16, and GateMDR is never asserted during the STR sequence.
- Opcode=1101: with Continue held 0, the FSM waits in PAUSE_A with LD_LED=1. Continue 1 moves it to PAUSE_B; Continue 0 then moves it to S18.
